// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage that sits in front of the control unit. It holds the
// program counter and reads instruction memory using the ihit handshake. The
// fetched word is latched onto Instr for decode. Once the datapath retires the
// current instruction, the unit computes the next PC from the decoded redirect
// signals. A decoded Halt stops fetching until the next reset.
//
// Ports:
//   CLK, nRST           clock (rising edge), asynchronous active-low reset
//   ihit, iload         instruction memory data-valid strobe and data word
//   iREN, iaddr         instruction read enable and address (iaddr = PC)
//   Instr, instr_valid  latched instruction word and its valid flag
//   advance             datapath has finished the current instruction
//   Jmp, JR, PCSrc      decoded redirect requests (JR > Jmp > PCSrc)
//   Halt                current instruction is HALT
//   imm26, imm16        jump target field and branch offset field
//   jr_target           register value used as the JR target
//   pc_plus4            PC + 4, also used as the JAL link value
//   halted              sticky halt indicator, cleared only by reset
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] Instr,
    output logic        instr_valid,
    input  logic        advance,
    input  logic        Jmp,
    input  logic        JR,
    input  logic        PCSrc,
    input  logic        Halt,
    input  logic [25:0] imm26,
    input  logic [15:0] imm16,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic        halted
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_EXEC   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_pc;
    logic [31:0] branch_offset;

    assign pc_plus4 = pc_q + 32'd4;

    // Branch offset is the sign-extended word offset, so shift it left by two.
    assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};

    // Next-PC selection. JR has the highest priority, then Jmp, then PCSrc.
    // This value is only used on the EXEC-and-advance edge.
    always_comb begin
        next_pc = pc_plus4;
        if (JR) begin
            next_pc = jr_target;
        end else if (Jmp) begin
            next_pc = {pc_plus4[31:28], imm26, 2'b00};
        end else if (PCSrc) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

    // Sequencer: FETCH waits for ihit, EXEC waits for advance, HALTED is terminal.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_FETCH: begin
                if (ihit) begin
                    instr_d = iload;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (advance) begin
                    if (Halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_FETCH;
            pc_q    <= PC_INIT;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Memory-side and decode-side outputs depend only on state and PC.
    // They have no combinational path from any input.
    assign iREN        = (state_q == ST_FETCH);
    assign iaddr       = pc_q;
    assign Instr       = instr_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural model tracks the
// following values:
//   - the PC
//   - the held instruction
//   - whether an instruction is outstanding
//   - whether the unit has halted
// The model next PC is computed with plain arithmetic. Directed scenario
// tasks run first, and then a randomized run is compared against the model
// on every cycle.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        advance;
    logic        Jmp;
    logic        JR;
    logic        PCSrc;
    logic        Halt;
    logic [25:0] imm26;
    logic [15:0] imm16;
    logic [31:0] jr_target;
    logic [31:0] pc_plus4;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_busy;
    bit          m_halted;

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
        .iREN(iREN), .iaddr(iaddr), .Instr(Instr), .instr_valid(instr_valid),
        .advance(advance), .Jmp(Jmp), .JR(JR), .PCSrc(PCSrc), .Halt(Halt),
        .imm26(imm26), .imm16(imm16), .jr_target(jr_target),
        .pc_plus4(pc_plus4), .halted(halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model reset: return to the start address with nothing held.
    task automatic model_reset();
        m_pc     = 32'h0000_0000;
        m_instr  = 32'h0000_0000;
        m_busy   = 0;
        m_halted = 0;
    endtask

    // Model target address for a retired instruction.
    function automatic logic [31:0] model_target();
        logic [31:0] seq;
        int          off;
        seq = m_pc + 32'd4;
        off = int'($signed(imm16));
        if (JR)         return jr_target;
        else if (Jmp)   return (seq & 32'hF000_0000) | (32'(imm26) * 32'd4);
        else if (PCSrc) return seq + 32'(off * 4);
        else            return seq;
    endfunction

    // Model clock edge: apply the rules to the inputs present at the edge.
    task automatic model_edge();
        if (m_halted) begin
        end else if (!m_busy) begin
            if (ihit) begin
                m_instr = iload;
                m_busy  = 1;
            end
        end else if (advance) begin
            m_busy = 0;
            if (Halt) m_halted = 1;
            else      m_pc = model_target();
        end
    endtask

    // One clock cycle. Inputs change only at posedge+1, so the model sees the
    // values that the DUT samples at the edge.
    task automatic tick();
        @(posedge CLK);
        if (nRST) model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        ihit = 0; iload = 0; advance = 0; Jmp = 0; JR = 0; PCSrc = 0;
        Halt = 0; imm26 = 0; imm16 = 0; jr_target = 0;
    endtask

    // Fetch one word. Assumes the DUT is in FETCH.
    task automatic fetch_word(input logic [31:0] w);
        ihit = 1; iload = w;
        tick();
        ihit = 0;
    endtask

    // Retire the current instruction with the given redirect inputs.
    task automatic retire(input logic jmp_i, input logic jr_i, input logic pcs_i,
                          input logic [25:0] i26, input logic [15:0] i16,
                          input logic [31:0] jt);
        Jmp = jmp_i; JR = jr_i; PCSrc = pcs_i; imm26 = i26; imm16 = i16; jr_target = jt;
        advance = 1;
        tick();
        clear_inputs();
    endtask

    // Use a JR retire to move the PC to a chosen address.
    task automatic go_to(input logic [31:0] target);
        fetch_word(32'h0800_0000);
        retire(0, 1, 0, 26'd0, 16'd0, target);
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 0;
        model_reset();
        #2;
        checks++; if (iREN !== 1'b1) begin errors++; $display("[TB] FAIL reset_iREN got %0b want 1", iREN); end
        checks++; if (iaddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_iaddr got %h want 00000000", iaddr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", instr_valid); end
        checks++; if (Instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h want 00000000", Instr); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("[TB] FAIL reset_pc_plus4 got %h want 00000004", pc_plus4); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %0b want 0", halted); end
        @(posedge CLK); #1;
        nRST = 1;
    endtask

    task automatic test_sequential();
        // ihit held high, advance pulsed in each EXEC cycle
        ihit = 1; iload = 32'h2001_0005;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (iaddr !== 32'(4 * i) || iREN !== 1'b1) begin
                errors++; $display("[TB] FAIL seq_iaddr[%0d] got %h/%0b want %h/1", i, iaddr, iREN, 32'(4 * i));
            end
            tick();
            checks++;
            if (Instr !== 32'h2001_0005 || instr_valid !== 1'b1 || iREN !== 1'b0) begin
                errors++; $display("[TB] FAIL seq_exec[%0d] got %h/%0b/%0b want 20010005/1/0", i, Instr, instr_valid, iREN);
            end
            if (i == 0) begin
                checks++;
                if (pc_plus4 !== 32'h4) begin errors++; $display("[TB] FAIL seq_pc_plus4 got %h want 00000004", pc_plus4); end
            end
            advance = 1;
            tick();
            advance = 0;
        end
        ihit = 0;
    endtask

    task automatic test_wait_states();
        // The PC is 12 after test_sequential.
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (iREN !== 1'b1 || iaddr !== 32'h0000_000C || instr_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL wait[%0d] got %0b/%h/%0b want 1/0000000c/0", i, iREN, iaddr, instr_valid);
            end
        end
        iload = 32'hDEAD_BEEF;
        fetch_word(32'hDEAD_BEEF);
        checks++;
        if (instr_valid !== 1'b1 || Instr !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL wait_exec got %0b/%h want 1/deadbeef", instr_valid, Instr);
        end
        retire(0, 0, 0, 26'd0, 16'd0, 32'd0);
    endtask

    task automatic test_redirects();
        go_to(32'h0040_0010);
        fetch_word(32'h1000_FFFC);
        retire(0, 0, 1, 26'd0, 16'hFFFC, 32'd0);
        checks++;
        if (iaddr !== 32'h0040_0004) begin errors++; $display("[TB] FAIL branch got %h want 00400004", iaddr); end

        go_to(32'h0040_0010);
        fetch_word(32'h0810_0000);
        retire(1, 0, 0, 26'h010_0000, 16'd0, 32'd0);
        checks++;
        if (iaddr !== 32'h0040_0000) begin errors++; $display("[TB] FAIL jump got %h want 00400000", iaddr); end

        go_to(32'h0040_0010);
        fetch_word(32'h03E0_0008);
        retire(1, 1, 1, 26'h010_0000, 16'hFFFC, 32'h0000_1234);
        checks++;
        if (iaddr !== 32'h0000_1234) begin errors++; $display("[TB] FAIL jr_priority got %h want 00001234", iaddr); end
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        go_to(32'h0000_0100);
        frozen = iaddr;
        fetch_word(32'hFFFF_FFFF);
        Halt = 1; advance = 1;
        tick();
        clear_inputs();
        checks++;
        if (halted !== 1'b1 || iREN !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL halt_enter got %0b/%0b/%0b want 1/0/0", halted, iREN, instr_valid);
        end
        ihit = 1; advance = 1; JR = 1; jr_target = 32'h0000_0800; iload = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (halted !== 1'b1 || iREN !== 1'b0 || iaddr !== frozen || Instr !== 32'hFFFF_FFFF) begin
                errors++; $display("[TB] FAIL halt_hold[%0d] got %0b/%0b/%h/%h want 1/0/%h/ffffffff", i, halted, iREN, iaddr, Instr, frozen);
            end
        end
        clear_inputs();
        nRST = 0;
        model_reset();
        #1;
        checks++;
        if (iaddr !== 32'h0 || halted !== 1'b0 || iREN !== 1'b1) begin
            errors++; $display("[TB] FAIL halt_reset got %h/%0b/%0b want 00000000/0/1", iaddr, halted, iREN);
        end
        nRST = 1;
    endtask

    task automatic test_reset_mid_fetch();
        go_to(32'h0000_0020);
        fetch_word(32'h2222_3333);
        #2;
        nRST = 0;
        model_reset();
        #1;
        checks++;
        if (iaddr !== 32'h0 || instr_valid !== 1'b0 || Instr !== 32'h0) begin
            errors++; $display("[TB] FAIL async_reset got %h/%0b/%h want 00000000/0/00000000", iaddr, instr_valid, Instr);
        end
        nRST = 1;
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC);
        fetch_word(32'h0000_0000);
        checks++;
        if (pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc_plus4 got %h want 00000000", pc_plus4); end
        retire(0, 0, 0, 26'd0, 16'd0, 32'd0);
        checks++;
        if (iaddr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_iaddr got %h want 00000000", iaddr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_addr;
        logic        exp_ren;
        logic        exp_valid;
        int          halt_age;
        halt_age = 0;
        for (int i = 0; i < 400; i++) begin
            ihit      = 1'($urandom_range(0, 1));
            advance   = 1'($urandom_range(0, 1));
            iload     = $urandom;
            Jmp       = 1'($urandom_range(0, 1));
            JR        = ($urandom_range(0, 3) == 0);
            PCSrc     = 1'($urandom_range(0, 1));
            Halt      = ($urandom_range(0, 29) == 0);
            imm26     = 26'($urandom);
            imm16     = 16'($urandom);
            jr_target = $urandom;
            tick();
            exp_ren   = !m_busy && !m_halted;
            exp_valid = m_busy && !m_halted;
            exp_addr  = m_pc;
            checks++;
            if ({iREN, instr_valid, halted, iaddr, Instr, pc_plus4} !==
                {exp_ren, exp_valid, m_halted, exp_addr, m_instr, exp_addr + 32'd4}) begin
                errors++;
                $display("[TB] FAIL random[%0d] got ren=%0b v=%0b h=%0b a=%h i=%h p4=%h want ren=%0b v=%0b h=%0b a=%h i=%h p4=%h",
                         i, iREN, instr_valid, halted, iaddr, Instr, pc_plus4,
                         exp_ren, exp_valid, m_halted, exp_addr, m_instr, exp_addr + 32'd4);
            end
            if (m_halted) halt_age++;
            if (halt_age > 6) begin
                halt_age = 0;
                nRST = 0;
                model_reset();
                #1;
                nRST = 1;
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        nRST = 0;
        model_reset();
        test_reset();
        test_sequential();
        test_wait_states();
        test_redirects();
        test_halt();
        test_reset_mid_fetch();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
